btn_debounce: RTL and testbench
===============================

# btn_debounce

Per-channel debouncer and edge detector for mechanical push-button/switch inputs. It sits directly downstream of the 3-flop input synchroniser and consumes its already-synchronised bus. It emits a clean level, single-cycle rise/fall pulses, and an optional auto-repeat pulse per channel to the control logic.

## Interface
- WIDTH, 4: number of independent channels.
- CNT_MAX, 16: consecutive stable samples required to accept a new level; legal range ≥ 1.
- REPEAT_CNT, 64: cycles between auto-repeat pulses; legal range ≥ 1; used only with the repeat feature.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- sync_i  in  WIDTH  synchronised raw inputs from the synchroniser stage; no further synchronisation is done here.
- level_o  out  WIDTH  debounced level per channel.
- rise_o  out  WIDTH  1-cycle pulse when level_o goes 0→1.
- fall_o  out  WIDTH  1-cycle pulse when level_o goes 1→0.
- repeat_o  out  WIDTH  auto-repeat pulse; port always present.

## Operation
- Each channel is fully independent: own 4-state FSM, stability counter of width $clog2(CNT_MAX+1), and repeat counter of width $clog2(REPEAT_CNT+1).
- FSM states:
  - LOW: level 0, counter 0. Sample 1: if CNT_MAX==1, commit to HIGH; else go to WAIT_H with counter=1. Sample 0: stay.
  - WAIT_H: level 0. Sample 1: counter+1; commit to HIGH when counter+1==CNT_MAX. Sample 0: return to LOW, counter cleared, no output activity.
  - HIGH: level 1. Symmetric to LOW, using WAIT_L.
  - WAIT_L: level 1. Symmetric to WAIT_H; commit goes to LOW.
- Commit to HIGH: level_o←1, rise_o←1 for one cycle. Commit to LOW: level_o←0, fall_o←1 for one cycle. Counter clears on commit.
- Counter never exceeds CNT_MAX and never wraps. A bounce of any length shorter than CNT_MAX samples produces no output change.
- All outputs are registered.
- rst mid-operation: every channel goes to LOW immediately. All counters clear, and all outputs go to 0 with no fall_o pulse. After release, a held-high input is re-debounced from zero and produces a fresh rise_o.
- Unused encodings of the FSM state recover to LOW.

## Timing
- Reset values: level_o=0, rise_o=0, fall_o=0, repeat_o=0.
- Latency: let edge E be the first clock edge that samples the new value on sync_i. level_o and the matching edge pulse update on edge E+CNT_MAX−1, i.e. at the CNT_MAX-th consecutive sample.
- rise_o and fall_o are asserted in the same cycle level_o changes and for exactly one cycle.
- rise_o and fall_o are never both high on a channel in the same cycle.
- Input toggling every cycle: level_o never changes (for CNT_MAX ≥ 2).

## Configuration
- Macro: BTN_DEBOUNCE_REPEAT_EN.
- Defined:
  - In HIGH, the repeat counter increments every cycle.
  - When it reaches REPEAT_CNT, repeat_o pulses for one cycle and the counter restarts from 0.
  - The first repeat pulse therefore occurs REPEAT_CNT cycles after the rise_o cycle, then every REPEAT_CNT cycles after that.
  - The repeat counter is held at 0 in every other state. A bounce into WAIT_L and back to HIGH restarts the repeat period.
  - repeat_o never coincides with rise_o.
- Undefined: repeat counters and logic are not generated, and repeat_o is tied to 0.

## Test plan
- Settings for all scenarios: WIDTH=2, CNT_MAX=4, REPEAT_CNT=8.
- Reset release with sync_i=00 for 20 cycles → all outputs stay 0.
- ch0 driven 1 and held → level_o[0]=1 and rise_o[0] pulses once, 3 cycles after the first edge sampling 1. ch1 is unaffected.
- ch0 high, then bounces 0,1,0,1 (1 cycle each) before settling at 0 → no output change during the bounce. fall_o[0] pulses once, 3 cycles after the final 0 is first sampled.
- ch0 held 1 for exactly 3 samples then 0 → no rise_o and level_o stays 0. Then both channels rise on the same edge → rise_o=11 in one cycle.
- rst asserted while ch1 is HIGH and ch1 input stays 1 → level_o[1]=0 immediately with no fall_o. After release, rise_o[1] fires 3 cycles after the first sampling edge.
- With BTN_DEBOUNCE_REPEAT_EN, ch0 held high for 30 cycles after rise → repeat_o[0] pulses at rise+8, rise+16, rise+24. Without the macro, repeat_o stays 0.

Source files
------------

// File: rtl/btn_debounce.sv
// Per-channel push-button debouncer with rise/fall edge pulses and optional auto-repeat.
// Define BTN_DEBOUNCE_REPEAT_EN to build the auto-repeat counters; otherwise repeat_o is tied low.

module btn_debounce_ch #(
    parameter int CNT_MAX    = 16,
    parameter int REPEAT_CNT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic sync,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rpt
);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX);

    if (CNT_MAX < 1 || REPEAT_CNT < 1) begin : g_bad_param
        $error("btn_debounce: CNT_MAX and REPEAT_CNT must be >= 1");
    end

    typedef enum logic [1:0] {LOW, WAIT_H, HIGH, WAIT_L} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          rise_n, fall_n, last;

    // The counter holds the samples already seen, so this sample completes the run
    assign last = (cnt + CW'(1)) == CNT_LAST;

    always_comb begin
        state_n = state;
        cnt_n   = '0;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        case (state)
            LOW: if (sync) begin
                if (CNT_MAX == 1) begin
                    state_n = HIGH;
                    rise_n  = 1'b1;
                end else begin
                    state_n = WAIT_H;
                    cnt_n   = CW'(1);
                end
            end
            WAIT_H: begin
                if (!sync)     state_n = LOW;
                else if (last) begin
                    state_n = HIGH;
                    rise_n  = 1'b1;
                end else       cnt_n = cnt + CW'(1);
            end
            HIGH: if (!sync) begin
                if (CNT_MAX == 1) begin
                    state_n = LOW;
                    fall_n  = 1'b1;
                end else begin
                    state_n = WAIT_L;
                    cnt_n   = CW'(1);
                end
            end
            WAIT_L: begin
                if (sync)      state_n = HIGH;
                else if (last) begin
                    state_n = LOW;
                    fall_n  = 1'b1;
                end else       cnt_n = cnt + CW'(1);
            end
            default: state_n = LOW;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOW;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            level <= (state_n == HIGH) || (state_n == WAIT_L);
            rise  <= rise_n;
            fall  <= fall_n;
        end
    end

`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CNT + 1);

    logic [RW-1:0] rcnt;

    // Counts only while settled HIGH; any excursion restarts the period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt <= '0;
            rpt  <= 1'b0;
        end else if (state == HIGH) begin
            if (rcnt + RW'(1) == RW'(REPEAT_CNT)) begin
                rcnt <= '0;
                rpt  <= 1'b1;
            end else begin
                rcnt <= rcnt + RW'(1);
                rpt  <= 1'b0;
            end
        end else begin
            rcnt <= '0;
            rpt  <= 1'b0;
        end
    end
`else
    assign rpt = 1'b0;
`endif

endmodule

module btn_debounce #(
    parameter int WIDTH      = 4,
    parameter int CNT_MAX    = 16,
    parameter int REPEAT_CNT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sync_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] repeat_o
);
    btn_debounce_ch #(
        .CNT_MAX    (CNT_MAX),
        .REPEAT_CNT (REPEAT_CNT)
    ) u_ch [WIDTH-1:0] (
        .clk   (clk),
        .rst   (rst),
        .sync  (sync_i),
        .level (level_o),
        .rise  (rise_o),
        .fall  (fall_o),
        .rpt   (repeat_o)
    );

endmodule

// File: tb/tb_btn_debounce.sv
// Randomized + directed bench for btn_debounce against a run-length reference model.
// Repeat expectations follow BTN_DEBOUNCE_REPEAT_EN as defined for the build.

module tb_btn_debounce;
    localparam int WIDTH      = 2;
    localparam int CNT_MAX    = 4;
    localparam int REPEAT_CNT = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] sync_i, level_o, rise_o, fall_o, repeat_o;

    btn_debounce #(
        .WIDTH      (WIDTH),
        .CNT_MAX    (CNT_MAX),
        .REPEAT_CNT (REPEAT_CNT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sync_i   (sync_i),
        .level_o  (level_o),
        .rise_o   (rise_o),
        .fall_o   (fall_o),
        .repeat_o (repeat_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference: accepted level plus length of the current run of samples disagreeing with it
    logic [WIDTH-1:0] m_lvl, m_rise, m_fall, m_rep;
    int               m_run [WIDTH];
`ifdef BTN_DEBOUNCE_REPEAT_EN
    int               m_hcnt[WIDTH];
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lvl  = '0;
        m_rise = '0;
        m_fall = '0;
        m_rep  = '0;
        for (int c = 0; c < WIDTH; c++) begin
            m_run[c] = 0;
`ifdef BTN_DEBOUNCE_REPEAT_EN
            m_hcnt[c] = 0;
`endif
        end
    endtask

    task automatic model_step(input logic [WIDTH-1:0] v);
        for (int c = 0; c < WIDTH; c++) begin
            m_rise[c] = 1'b0;
            m_fall[c] = 1'b0;
            m_rep[c]  = 1'b0;
`ifdef BTN_DEBOUNCE_REPEAT_EN
            if (m_lvl[c] && m_run[c] == 0) begin
                m_hcnt[c]++;
                if (m_hcnt[c] == REPEAT_CNT) begin
                    m_rep[c]  = 1'b1;
                    m_hcnt[c] = 0;
                end
            end else m_hcnt[c] = 0;
`endif
            if (v[c] != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == CNT_MAX) begin
                    m_lvl[c] = v[c];
                    m_run[c] = 0;
                    if (v[c]) m_rise[c] = 1'b1;
                    else      m_fall[c] = 1'b1;
                end
            end else m_run[c] = 0;
        end
    endtask

    task automatic chk_all(input string pfx);
        chk({pfx, ".level"},  32'(level_o),  32'(m_lvl));
        chk({pfx, ".rise"},   32'(rise_o),   32'(m_rise));
        chk({pfx, ".fall"},   32'(fall_o),   32'(m_fall));
        chk({pfx, ".repeat"}, 32'(repeat_o), 32'(m_rep));
    endtask

    task automatic cyc(input logic [WIDTH-1:0] v, input string pfx);
        sync_i = v;
        @(posedge clk);
        model_step(v);
        #1;
        chk_all(pfx);
    endtask

    initial begin
        logic [WIDTH-1:0] cur;
        int nrep;

        rst    = 1'b1;
        sync_i = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset");
        rst = 1'b0;

        repeat (20) cyc(2'b00, "idle");
        chk("idle.level_const", 32'(level_o), 32'h0);

        // single-channel rise
        repeat (3) cyc(2'b01, "s2");
        chk("s2.no_early_rise", 32'(rise_o), 32'h0);
        cyc(2'b01, "s2");
        chk("s2.rise", 32'(rise_o), 32'h1);
        chk("s2.level", 32'(level_o), 32'h1);
        cyc(2'b01, "s2");
        chk("s2.single_pulse", 32'(rise_o), 32'h0);

        // bounce then settle low
        cyc(2'b00, "s3"); cyc(2'b01, "s3"); cyc(2'b00, "s3"); cyc(2'b01, "s3");
        chk("s3.bounce_level", 32'(level_o), 32'h1);
        repeat (3) cyc(2'b00, "s3");
        chk("s3.no_early_fall", 32'(fall_o), 32'h0);
        cyc(2'b00, "s3");
        chk("s3.fall", 32'(fall_o), 32'h1);
        chk("s3.level", 32'(level_o), 32'h0);

        // short pulse rejected, then simultaneous rise
        repeat (3) cyc(2'b01, "s4");
        cyc(2'b00, "s4");
        chk("s4.short_level", 32'(level_o), 32'h0);
        repeat (3) cyc(2'b11, "s4");
        cyc(2'b11, "s4");
        chk("s4.rise_both", 32'(rise_o), 32'h3);

        // reset while high, input held high
        cyc(2'b11, "s5");
        rst = 1'b1;
        #1;
        model_reset();
        chk("s5.rst_level", 32'(level_o), 32'h0);
        chk("s5.rst_fall", 32'(fall_o), 32'h0);
        @(posedge clk);
        #1;
        chk("s5.rst_hold", 32'(level_o), 32'h0);
        rst = 1'b0;
        repeat (3) cyc(2'b11, "s5");
        chk("s5.no_early_rise", 32'(rise_o), 32'h0);
        cyc(2'b11, "s5");
        chk("s5.rerise", 32'(rise_o), 32'h3);

        // auto-repeat over 30 held cycles
        nrep = 0;
        for (int k = 1; k <= 30; k++) begin
            cyc(2'b11, "s6");
            nrep += int'(repeat_o[0]);
`ifdef BTN_DEBOUNCE_REPEAT_EN
            if (k == 8 || k == 16 || k == 24) chk("s6.rep_at", 32'(repeat_o[0]), 32'h1);
`endif
        end
`ifdef BTN_DEBOUNCE_REPEAT_EN
        chk("s6.rep_count", 32'(nrep), 32'd3);
`else
        chk("s6.rep_count", 32'(nrep), 32'd0);
`endif

        // randomized: alternating calm and noisy phases, occasional reset
        cur = sync_i;
        for (int k = 0; k < 3000; k++) begin
            int thr;
            thr = ((k / 500) % 2 == 1) ? 5 : 1;
            for (int c = 0; c < WIDTH; c++)
                if ($urandom_range(0, 9) < thr) cur[c] = ~cur[c];
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                chk_all("rnd.rst");
                @(negedge clk);
                rst = 1'b0;
            end
            cyc(cur, "rnd");
            chk("rnd.excl", 32'(rise_o & fall_o), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
